// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: IDLE -> ROUNDS (64) -> DONE sequencing.
// Optional abort input enabled by SHA256_ROUND_CTRL_ABORT_EN.
module sha256_round_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        next,
`ifdef SHA256_ROUND_CTRL_ABORT_EN
  input  logic        abort,
`endif
  output logic        ready,
  output logic        digest_valid,
  output logic        w_init,
  output logic        w_next,
  output logic        digest_init,
  output logic        state_init,
  output logic        state_update,
  output logic        digest_update,
  output logic [5:0]  t_idx,
  output logic [31:0] block_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUNDS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   abort_hit;

`ifdef SHA256_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort & (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (init | next) state_nxt = ROUNDS;
      ROUNDS:  if (t_idx == 6'd63) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // Strobes are pure decodes; reset forces them low in the same cycle.
  always_comb begin
    ready         = reset | (state == IDLE);
    w_init        = 1'b0;
    w_next        = 1'b0;
    digest_init   = 1'b0;
    state_init    = 1'b0;
    state_update  = 1'b0;
    digest_update = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          w_init      = init | next;
          state_init  = init | next;
          digest_init = init;
        end
        ROUNDS: begin
          w_next       = 1'b1;
          state_update = 1'b1;
        end
        DONE:    digest_update = ~abort_hit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_idx        <= 6'd0;
      block_cnt    <= 32'd0;
      digest_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (init | next) begin
            t_idx        <= 6'd0;
            digest_valid <= 1'b0;
          end
          if (init) block_cnt <= 32'd0;
        end
        ROUNDS: begin
          if (abort_hit) t_idx <= 6'd0;
          else           t_idx <= t_idx + 6'd1;
        end
        DONE: begin
          if (!abort_hit) begin
            digest_valid <= 1'b1;
            if (!(&block_cnt)) block_cnt <= block_cnt + 32'd1;
          end
        end
        default: t_idx <= 6'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: directed table, hand sequences, random vs model.
// Define SHA256_ROUND_CTRL_ABORT_EN to also exercise the abort input.
module tb_sha256_round_ctrl;

`ifdef SHA256_ROUND_CTRL_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic        next = 1'b0;
  logic        abort_s = 1'b0;
  logic        ready, digest_valid;
  logic        w_init, w_next, digest_init;
  logic        state_init, state_update, digest_update;
  logic [5:0]  t_idx;
  logic [31:0] block_cnt;

  int tests = 0;
  int failed = 0;

  // model: pos = cycles since acceptance (1..64 rounds, 65 done), -1 idle
  int          m_pos = -1;
  logic [31:0] m_cnt = 0;
  logic        m_valid = 0;

  sha256_round_ctrl dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .next(next),
`ifdef SHA256_ROUND_CTRL_ABORT_EN
    .abort(abort_s),
`endif
    .ready(ready),
    .digest_valid(digest_valid),
    .w_init(w_init),
    .w_next(w_next),
    .digest_init(digest_init),
    .state_init(state_init),
    .state_update(state_update),
    .digest_update(digest_update),
    .t_idx(t_idx),
    .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          gap;
    bit          i;
    bit          n;
    logic [7:0]  flags;
    logic [5:0]  t;
    logic [31:0] cnt;
  } row_t;

  row_t tbl[13];

  function automatic row_t mk(int g, bit i, bit n,
                              logic [7:0] f, int t, int c);
    row_t r;
    r.gap = g; r.i = i; r.n = n;
    r.flags = f; r.t = 6'(t); r.cnt = 32'(c);
    return r;
  endfunction

  function automatic logic [45:0] act_vec();
    return {ready, digest_valid, w_init, digest_init, state_init,
            state_update, w_next, digest_update, t_idx, block_cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] a,
                     input logic [63:0] e);
    tests++;
    if (a !== e) begin
      failed++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, a, e);
    end
  endtask

  function automatic bit m_ab();
    return ABORT && abort_s && (m_pos >= 1);
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_pos = -1; m_cnt = 0; m_valid = 0;
    end else if (m_ab()) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (init | next) begin
        m_pos = 1; m_valid = 0;
        if (init) m_cnt = 0;
      end
    end else if (m_pos == 65) begin
      m_pos = -1; m_valid = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  task automatic model_check();
    bit idle, rnd, go;
    logic [5:0] t;
    idle = (m_pos < 0);
    rnd = (m_pos >= 1) && (m_pos <= 64);
    go = !reset && idle && (init | next);
    t = rnd ? 6'(m_pos - 1) : 6'd0;
    chk("model", 64'(act_vec()),
        64'({reset | idle, m_valid, go, !reset && idle && init, go,
             !reset && rnd, !reset && rnd,
             !reset && m_pos == 65 && !m_ab(), t, m_cnt}));
  endtask

  task automatic cyc(input bit i, input bit n, input bit r, input bit a);
    @(posedge clk);
    model_edge();
    #1;
    init = i; next = n; reset = r; abort_s = a;
    #1;
    model_check();
  endtask

  initial begin
    int cnt0, ncyc, du_seen;
    // flags: ready dv w_init digest_init state_init su w_next du
    tbl[0]  = mk(0,  1, 0, 8'b10111000, 0,  0);
    tbl[1]  = mk(0,  0, 0, 8'b00000110, 0,  0);
    tbl[2]  = mk(62, 0, 0, 8'b00000110, 63, 0);
    tbl[3]  = mk(0,  0, 0, 8'b00000001, 0,  0);
    tbl[4]  = mk(0,  0, 0, 8'b11000000, 0,  1);
    tbl[5]  = mk(9,  0, 1, 8'b11101000, 0,  1);
    tbl[6]  = mk(64, 0, 0, 8'b00000001, 0,  1);
    tbl[7]  = mk(0,  0, 0, 8'b11000000, 0,  2);
    tbl[8]  = mk(0,  1, 1, 8'b11111000, 0,  2);
    tbl[9]  = mk(0,  0, 0, 8'b00000110, 0,  0);
    tbl[10] = mk(29, 1, 1, 8'b00000110, 30, 0);
    tbl[11] = mk(33, 0, 0, 8'b00000001, 0,  0);
    tbl[12] = mk(0,  0, 0, 8'b11000000, 0,  1);

    cyc(0, 0, 1, 0);
    chk("reset_state", 64'(act_vec()), 64'({8'b10000000, 6'd0, 32'd0}));

    for (int k = 0; k < 13; k++) begin
      for (int g = 0; g < tbl[k].gap; g++) cyc(0, 0, 0, 0);
      cyc(tbl[k].i, tbl[k].n, 0, 0);
      chk($sformatf("row%0d", k), 64'(act_vec()),
          64'({tbl[k].flags, tbl[k].t, tbl[k].cnt}));
    end

    // reset in the middle of the rounds
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 100 && t_idx != 6'd40; k++) cyc(0, 0, 0, 0);
    chk("reach_t40", 64'(t_idx), 64'd40);
    cyc(0, 0, 1, 0);
    chk("rst_cycle", 64'({ready, w_init, digest_init, state_init,
                          state_update, w_next, digest_update}),
        64'(7'b1000000));
    cyc(0, 0, 0, 0);
    chk("rst_after", 64'({ready, digest_valid, digest_update,
                          t_idx, block_cnt}), 64'({3'b100, 38'd0}));
    du_seen = 0;
    for (int k = 0; k < 80; k++) begin
      cyc(0, 0, 0, 0);
      if (digest_update) du_seen++;
    end
    chk("rst_no_du", 64'(du_seen), 64'd0);

`ifdef SHA256_ROUND_CTRL_ABORT_EN
    cyc(1, 0, 0, 0);
    cnt0 = int'(m_cnt);
    for (int k = 0; k < 100 && t_idx != 6'd20; k++) cyc(0, 0, 0, 0);
    chk("reach_t20", 64'(t_idx), 64'd20);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("abort_idle", 64'({ready, digest_valid, t_idx, block_cnt}),
        64'({2'b10, 6'd0, 32'(cnt0)}));
    cyc(0, 1, 0, 0);
    ncyc = 0;
    du_seen = 0;
    do begin
      cyc(0, 0, 0, 0);
      ncyc++;
      if (digest_update) du_seen++;
    end while (!ready && ncyc < 100);
    chk("abort_next_len", 64'(ncyc), 64'd66);
    chk("abort_next_du", 64'(du_seen), 64'd1);
    chk("abort_next_cnt", 64'(block_cnt), 64'(cnt0 + 1));
`else
    cnt0 = 0;
    ncyc = 0;
`endif

    // random stimulus against the model
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
